// File: rtl/utm_tag_qmgr.sv
// rtl/utm_tag_qmgr.sv - multi-channel unicast tag queue manager
//
// Holds one FIFO of unicast tags per egress channel. Tags enter from the
// tagring side and leave on PFS scheduler requests. Each channel exports
// non-empty, occupancy and hysteretic XOFF status, and can be flushed.
//
// Ports:
//   clk, rst                clock, synchronous active-high reset
//   enq_valid/ch/tag/ready  enqueue handshake (ready is combinational)
//   deq_req/ch              dequeue request
//   deq_valid/tag/err       registered dequeue response, 1-cycle latency
//   ne_vec, xoff_vec        registered per-channel non-empty / XOFF
//   cfg_xoff_thr/xon_thr    XOFF set / clear thresholds (xon < xoff)
//   flush, flush_ch         per-channel flush pulse
//   occ_rd_ch, occ_rd_cnt   combinational occupancy read port
//   drop_cnt                saturating count of enqueues dropped when full
module utm_tag_qmgr #(
  parameter int N_CH         = 16,
  parameter int DEPTH        = 32,
  parameter int TAG_W        = 64,
  parameter int DROP_ON_FULL = 0,
  parameter int CH_W         = $clog2(N_CH),
  parameter int CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq_valid,
  input  logic [CH_W-1:0]  enq_ch,
  input  logic [TAG_W-1:0] enq_tag,
  output logic             enq_ready,
  input  logic             deq_req,
  input  logic [CH_W-1:0]  deq_ch,
  output logic             deq_valid,
  output logic [TAG_W-1:0] deq_tag,
  output logic             deq_err,
  output logic [N_CH-1:0]  ne_vec,
  output logic [N_CH-1:0]  xoff_vec,
  input  logic [CNT_W-1:0] cfg_xoff_thr,
  input  logic [CNT_W-1:0] cfg_xon_thr,
  input  logic             flush,
  input  logic [CH_W-1:0]  flush_ch,
  input  logic [CH_W-1:0]  occ_rd_ch,
  output logic [CNT_W-1:0] occ_rd_cnt,
  output logic [15:0]      drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam bit DROP  = (DROP_ON_FULL != 0);
  localparam logic [CH_W:0] N_CH_L = (CH_W+1)'(N_CH);

  logic [TAG_W-1:0] mem_q [N_CH][DEPTH];

  logic [PTR_W-1:0] rd_ptr_q [N_CH];
  logic [PTR_W-1:0] rd_ptr_d [N_CH];
  logic [PTR_W-1:0] wr_ptr_q [N_CH];
  logic [PTR_W-1:0] wr_ptr_d [N_CH];
  logic [CNT_W-1:0] cnt_q    [N_CH];
  logic [CNT_W-1:0] cnt_d    [N_CH];
  logic [N_CH-1:0]  ne_q, ne_d;
  logic [N_CH-1:0]  xoff_q, xoff_d;

  logic             deq_valid_q;
  logic             deq_err_q;
  logic [TAG_W-1:0] deq_tag_q;
  logic [15:0]      drop_cnt_q;

  // Range checks; out-of-range indices are clamped to 0 so that array reads
  // never go out of bounds, and the in-range flags gate every action.
  logic            enq_in_rng, deq_in_rng, flush_in_rng, occ_in_rng;
  logic [CH_W-1:0] enq_idx, deq_idx, occ_idx;

  assign enq_in_rng   = ({1'b0, enq_ch}    < N_CH_L);
  assign deq_in_rng   = ({1'b0, deq_ch}    < N_CH_L);
  assign flush_in_rng = ({1'b0, flush_ch}  < N_CH_L);
  assign occ_in_rng   = ({1'b0, occ_rd_ch} < N_CH_L);
  assign enq_idx      = enq_in_rng ? enq_ch    : '0;
  assign deq_idx      = deq_in_rng ? deq_ch    : '0;
  assign occ_idx      = occ_in_rng ? occ_rd_ch : '0;

  logic flush_v, enq_flushed, deq_flushed;
  logic full_enq, empty_deq;
  logic enq_fire, enq_drop, deq_fire, deq_miss;

  assign flush_v     = flush && flush_in_rng;
  assign enq_flushed = flush_v && (flush_ch == enq_ch);
  assign deq_flushed = flush_v && (flush_ch == deq_ch);

  // Full/empty come from registered counts only: no same-cycle bypass.
  assign full_enq  = (cnt_q[enq_idx] == CNT_W'(DEPTH));
  assign empty_deq = (cnt_q[deq_idx] == '0);

  assign enq_ready = enq_in_rng && !enq_flushed && (DROP || !full_enq);
  assign enq_fire  = enq_valid && enq_ready && !full_enq;
  assign enq_drop  = enq_valid && enq_ready && full_enq;
  assign deq_fire  = deq_req && deq_in_rng && !deq_flushed && !empty_deq;
  assign deq_miss  = deq_req && !deq_fire;

  always_comb begin
    ne_d   = '0;
    xoff_d = xoff_q;
    for (int i = 0; i < N_CH; i++) begin
      rd_ptr_d[i] = rd_ptr_q[i];
      wr_ptr_d[i] = wr_ptr_q[i];
      cnt_d[i]    = cnt_q[i];
      if (flush_v && (flush_ch == CH_W'(i))) begin
        // Flush wins over any same-cycle enqueue or dequeue on the channel.
        rd_ptr_d[i] = '0;
        wr_ptr_d[i] = '0;
        cnt_d[i]    = '0;
        xoff_d[i]   = 1'b0;
      end else begin
        if (enq_fire && (enq_idx == CH_W'(i)))
          wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
        if (deq_fire && (deq_idx == CH_W'(i)))
          rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
        case ({enq_fire && (enq_idx == CH_W'(i)), deq_fire && (deq_idx == CH_W'(i))})
          2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
          2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
          default: cnt_d[i] = cnt_q[i];
        endcase
        // Hysteresis: between the two thresholds the previous state holds.
        if (cnt_d[i] >= cfg_xoff_thr)
          xoff_d[i] = 1'b1;
        else if (cnt_d[i] <= cfg_xon_thr)
          xoff_d[i] = 1'b0;
      end
      ne_d[i] = (cnt_d[i] != '0);
    end
  end

  // Tag storage has no reset; contents are only ever read behind a count.
  always_ff @(posedge clk) begin
    if (enq_fire)
      mem_q[enq_idx][wr_ptr_q[enq_idx]] <= enq_tag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      ne_q        <= '0;
      xoff_q      <= '0;
      deq_valid_q <= 1'b0;
      deq_err_q   <= 1'b0;
      deq_tag_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        rd_ptr_q[i] <= rd_ptr_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      ne_q        <= ne_d;
      xoff_q      <= xoff_d;
      deq_valid_q <= deq_fire;
      deq_err_q   <= deq_miss;
      // On a miss the tag register keeps its previous value.
      if (deq_fire)
        deq_tag_q <= mem_q[deq_idx][rd_ptr_q[deq_idx]];
      if (enq_drop && (drop_cnt_q != 16'hFFFF))
        drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign deq_valid  = deq_valid_q;
  assign deq_err    = deq_err_q;
  assign deq_tag    = deq_tag_q;
  assign ne_vec     = ne_q;
  assign xoff_vec   = xoff_q;
  assign drop_cnt   = drop_cnt_q;
  assign occ_rd_cnt = occ_in_rng ? cnt_q[occ_idx] : '0;

endmodule

// File: tb/tb_utm_tag_qmgr.sv
// tb/tb_utm_tag_qmgr.sv - scoreboard testbench for utm_tag_qmgr
module tb_utm_tag_qmgr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0 backpressures when full, instance 1 drops when full.
  logic        rst_s  [2];
  logic        ev     [2];
  logic [1:0]  ech    [2];
  logic [15:0] etag   [2];
  logic        er     [2];
  logic        dr     [2];
  logic [1:0]  dch    [2];
  logic        dv     [2];
  logic [15:0] dtag   [2];
  logic        de     [2];
  logic [3:0]  ne     [2];
  logic [3:0]  xo     [2];
  logic        fl     [2];
  logic [1:0]  fch    [2];
  logic [1:0]  occ_ch [2];
  logic [2:0]  occ    [2];
  logic [15:0] dcnt   [2];
  logic [2:0]  xoff_thr = 3'd3;
  logic [2:0]  xon_thr  = 3'd1;

  utm_tag_qmgr #(.N_CH(4), .DEPTH(4), .TAG_W(16), .DROP_ON_FULL(0)) dut0 (
    .clk(clk), .rst(rst_s[0]),
    .enq_valid(ev[0]), .enq_ch(ech[0]), .enq_tag(etag[0]), .enq_ready(er[0]),
    .deq_req(dr[0]), .deq_ch(dch[0]), .deq_valid(dv[0]), .deq_tag(dtag[0]), .deq_err(de[0]),
    .ne_vec(ne[0]), .xoff_vec(xo[0]), .cfg_xoff_thr(xoff_thr), .cfg_xon_thr(xon_thr),
    .flush(fl[0]), .flush_ch(fch[0]), .occ_rd_ch(occ_ch[0]), .occ_rd_cnt(occ[0]),
    .drop_cnt(dcnt[0])
  );

  utm_tag_qmgr #(.N_CH(4), .DEPTH(4), .TAG_W(16), .DROP_ON_FULL(1)) dut1 (
    .clk(clk), .rst(rst_s[1]),
    .enq_valid(ev[1]), .enq_ch(ech[1]), .enq_tag(etag[1]), .enq_ready(er[1]),
    .deq_req(dr[1]), .deq_ch(dch[1]), .deq_valid(dv[1]), .deq_tag(dtag[1]), .deq_err(de[1]),
    .ne_vec(ne[1]), .xoff_vec(xo[1]), .cfg_xoff_thr(xoff_thr), .cfg_xon_thr(xon_thr),
    .flush(fl[1]), .flush_ch(fch[1]), .occ_rd_ch(occ_ch[1]), .occ_rd_cnt(occ[1]),
    .drop_cnt(dcnt[1])
  );

  typedef struct packed {
    logic        u;
    logic        err;
    logic [15:0] tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every response pulse pops one expectation.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (dv[u] || de[u]) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL sb_unexpected: dut%0d valid=%0b err=%0b tag=%0h", u, dv[u], de[u], dtag[u]);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_unit",  32'(u),      32'(e.u));
          chk("sb_valid", 32'(dv[u]),  32'(!e.err));
          chk("sb_err",   32'(de[u]),  32'(e.err));
          chk("sb_tag",   32'(dtag[u]), 32'(e.tag));
        end
      end
    end
  end

  task automatic step(input int u, input logic e_v, input logic [1:0] e_c, input logic [15:0] e_t,
                      input logic exp_rdy, input logic d_r, input logic [1:0] d_c,
                      input logic f_v, input logic [1:0] f_c);
    ev[u] = e_v; ech[u] = e_c; etag[u] = e_t;
    dr[u] = d_r; dch[u] = d_c; fl[u] = f_v; fch[u] = f_c;
    #1;
    if (e_v) chk("enq_ready", 32'(er[u]), 32'(exp_rdy));
    @(posedge clk);
    #1;
    ev[u] = 1'b0; dr[u] = 1'b0; fl[u] = 1'b0;
  endtask

  task automatic enq(input int u, input logic [1:0] c, input logic [15:0] t, input logic rdy);
    step(u, 1'b1, c, t, rdy, 1'b0, 2'd0, 1'b0, 2'd0);
  endtask

  task automatic deq(input int u, input logic [1:0] c, input logic err, input logic [15:0] t);
    sb.push_back('{u: u[0], err: err, tag: t});
    step(u, 1'b0, 2'd0, 16'h0, 1'b0, 1'b1, c, 1'b0, 2'd0);
  endtask

  task automatic occ_chk(input int u, input logic [1:0] c, input logic [2:0] exp);
    occ_ch[u] = c;
    #1;
    chk($sformatf("occ_dut%0d_ch%0d", u, c), 32'(occ[u]), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst_s[u] = 1'b1; ev[u] = 1'b0; ech[u] = '0; etag[u] = '0; dr[u] = 1'b0;
      dch[u] = '0; fl[u] = 1'b0; fch[u] = '0; occ_ch[u] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst_s[0] = 1'b0;
    rst_s[1] = 1'b0;

    // Reset state
    for (int u = 0; u < 2; u++) begin
      chk("rst_deq_valid", 32'(dv[u]), 0);
      chk("rst_deq_err",   32'(de[u]), 0);
      chk("rst_deq_tag",   32'(dtag[u]), 0);
      chk("rst_ne",        32'(ne[u]), 0);
      chk("rst_xoff",      32'(xo[u]), 0);
      chk("rst_drop",      32'(dcnt[u]), 0);
    end

    // Fill ch2, fifth enqueue is refused
    for (int i = 0; i < 4; i++) enq(0, 2'd2, 16'h00A0 + 16'(i), 1'b1);
    enq(0, 2'd2, 16'h00A4, 1'b0);
    occ_chk(0, 2'd2, 3'd4);
    chk("ne2_full",   32'(ne[0][2]), 1);
    chk("xoff2_full", 32'(xo[0][2]), 1);
    for (int i = 0; i < 4; i++) deq(0, 2'd2, 1'b0, 16'h00A0 + 16'(i));
    chk("ne2_drained", 32'(ne[0][2]), 0);

    // Empty dequeue, then same-cycle enqueue+dequeue on an empty channel
    deq(0, 2'd1, 1'b1, 16'h00A3);
    sb.push_back('{u: 1'b0, err: 1'b1, tag: 16'h00A3});
    step(0, 1'b1, 2'd1, 16'h00B1, 1'b1, 1'b1, 2'd1, 1'b0, 2'd0);
    deq(0, 2'd1, 1'b0, 16'h00B1);

    // Pointer wrap with simultaneous enqueue/dequeue, occupancy stays at 1
    enq(0, 2'd0, 16'h00C0, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      sb.push_back('{u: 1'b0, err: 1'b0, tag: 16'h00C0 + 16'(i - 1)});
      step(0, 1'b1, 2'd0, 16'h00C0 + 16'(i), 1'b1, 1'b1, 2'd0, 1'b0, 2'd0);
      occ_chk(0, 2'd0, 3'd1);
    end
    deq(0, 2'd0, 1'b0, 16'h00CA);
    occ_chk(0, 2'd0, 3'd0);

    // XOFF hysteresis on ch0, set at 3, clear at 1
    enq(0, 2'd0, 16'h00D0, 1'b1);
    enq(0, 2'd0, 16'h00D1, 1'b1);
    chk("xoff0_cnt2_rise", 32'(xo[0][0]), 0);
    enq(0, 2'd0, 16'h00D2, 1'b1);
    chk("xoff0_cnt3", 32'(xo[0][0]), 1);
    deq(0, 2'd0, 1'b0, 16'h00D0);
    chk("xoff0_cnt2_hold", 32'(xo[0][0]), 1);
    deq(0, 2'd0, 1'b0, 16'h00D1);
    chk("xoff0_cnt1", 32'(xo[0][0]), 0);
    deq(0, 2'd0, 1'b0, 16'h00D2);

    // Flush ch2 with same-cycle enqueue and dequeue on ch2
    for (int i = 0; i < 3; i++) enq(0, 2'd2, 16'h00E0 + 16'(i), 1'b1);
    chk("xoff2_pre_flush", 32'(xo[0][2]), 1);
    sb.push_back('{u: 1'b0, err: 1'b1, tag: 16'h00D2});
    step(0, 1'b1, 2'd2, 16'h00E3, 1'b0, 1'b1, 2'd2, 1'b1, 2'd2);
    occ_chk(0, 2'd2, 3'd0);
    chk("ne2_flush",   32'(ne[0][2]), 0);
    chk("xoff2_flush", 32'(xo[0][2]), 0);
    deq(0, 2'd2, 1'b1, 16'h00D2);

    // Independent enqueue and dequeue on different channels
    enq(0, 2'd1, 16'h00F0, 1'b1);
    sb.push_back('{u: 1'b0, err: 1'b0, tag: 16'h00F0});
    step(0, 1'b1, 2'd3, 16'h00F1, 1'b1, 1'b1, 2'd1, 1'b0, 2'd0);
    occ_chk(0, 2'd3, 3'd1);
    occ_chk(0, 2'd1, 3'd0);

    // Reset mid-burst discards queued tags and the in-flight response
    enq(0, 2'd0, 16'h0010, 1'b1);
    enq(0, 2'd0, 16'h0011, 1'b1);
    rst_s[0] = 1'b1;
    step(0, 1'b0, 2'd0, 16'h0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0);
    rst_s[0] = 1'b0;
    chk("mid_rst_valid", 32'(dv[0]), 0);
    chk("mid_rst_err",   32'(de[0]), 0);
    chk("mid_rst_tag",   32'(dtag[0]), 0);
    chk("mid_rst_ne",    32'(ne[0]), 0);
    chk("mid_rst_xoff",  32'(xo[0]), 0);
    occ_chk(0, 2'd0, 3'd0);
    occ_chk(0, 2'd3, 3'd0);

    // Drop-on-full instance: three drops, first four tags survive
    for (int i = 0; i < 7; i++) enq(1, 2'd3, 16'h0030 + 16'(i), 1'b1);
    chk("drop_cnt", 32'(dcnt[1]), 3);
    occ_chk(1, 2'd3, 3'd4);
    for (int i = 0; i < 4; i++) deq(1, 2'd3, 1'b0, 16'h0030 + 16'(i));
    deq(1, 2'd3, 1'b1, 16'h0033);
    chk("drop_cnt_hold", 32'(dcnt[1]), 3);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
